// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP MAC slice sequencer (state encoding, slice latencies, default widths).
package dsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

  localparam int DSP_MUL_LAT   = 2;
  // The slice needs one EN cycle per pipeline stage after the last pair before its accumulator is final.
  localparam int DRAIN_CYCLES  = DSP_MUL_LAT;

  localparam int DEF_WIDTH_OP1 = 18;
  localparam int DEF_WIDTH_OP2 = 18;
  localparam int DEF_WIDTH_OUT = 48;

endpackage

// File: rtl/dsp_dot_seq.sv
// Sequences signed operand pairs into one DSP MAC slice; result valid 3 cycles after the last pair, held until out_ready.
// in_ready only in STREAM; the initial accumulator value is bias when DOT_SEQ_BIAS_EN is defined, else 0.
module dsp_dot_seq
  import dsp_pkg::*;
#(
  parameter int WIDTH_OP1 = DEF_WIDTH_OP1,
  parameter int WIDTH_OP2 = DEF_WIDTH_OP2,
  parameter int WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int LEN_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_OP1-1:0] in_op1,
  input  logic [WIDTH_OP2-1:0] in_op2,
  input  logic                 in_last,
  input  logic [WIDTH_OUT-1:0] bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic [LEN_W-1:0]     out_len,
  output logic                 dsp_en,
  output logic                 dsp_acc_en,
  output logic                 dsp_acc_in_en,
  output logic [WIDTH_OP1-1:0] dsp_op1,
  output logic [WIDTH_OP2-1:0] dsp_op2,
  output logic [WIDTH_OUT-1:0] dsp_acc,
  input  logic [WIDTH_OUT-1:0] dsp_out
);

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t               state, state_nxt;
  logic [LEN_W-1:0]     cnt, cnt_nxt;
  logic [1:0]           drain_cnt, drain_cnt_nxt;
  logic [WIDTH_OUT-1:0] init_acc;

`ifdef DOT_SEQ_BIAS_EN
  assign init_acc = bias;
`else
  logic [WIDTH_OUT-1:0] bias_unused;
  assign bias_unused = bias;
  assign init_acc    = '0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    drain_cnt_nxt = drain_cnt;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_len       = '0;
    dsp_en        = 1'b0;
    dsp_acc_en    = 1'b0;
    dsp_acc_in_en = 1'b0;
    dsp_op1       = '0;
    dsp_op2       = '0;
    dsp_acc       = '0;
    // Outputs are forced quiet for the whole reset window, not just after the first edge.
    if (RSTN) begin
      case (state)
        IDLE: begin
          if (in_valid) state_nxt = LOAD;
        end
        LOAD: begin
          dsp_en        = 1'b1;
          dsp_acc_in_en = 1'b1;
          dsp_acc       = init_acc;
          cnt_nxt       = '0;
          state_nxt     = STREAM;
        end
        STREAM: begin
          in_ready = 1'b1;
          dsp_en   = 1'b1;
          if (in_valid) begin
            dsp_op1    = in_op1;
            dsp_op2    = in_op2;
            dsp_acc_en = 1'b1;
            if (cnt != {LEN_W{1'b1}}) cnt_nxt = cnt + 1'b1;
            if (in_last) begin
              drain_cnt_nxt = '0;
              state_nxt     = DRAIN;
            end
          end
        end
        DRAIN: begin
          dsp_en        = 1'b1;
          drain_cnt_nxt = drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) state_nxt = RESULT;
        end
        RESULT: begin
          out_valid = 1'b1;
          out_data  = dsp_out;
          out_len   = cnt;
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
